// File: rtl/pll_clken_pkg.sv
// Shared types and constants for the PLL lock sequencer and clock-enable dividers.
package pll_clken_pkg;

   localparam int LOSS_CNT_W  = 16;
   localparam int SYNC_STAGES = 2;
   localparam int DIV_MIN     = 2;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_t;

endpackage

// File: rtl/pll_clken_if.sv
// Bundle of lock input, divider controls and sequencer outputs.
// PLL_CLKEN_LOSS_CNT_EN adds the lock-loss counter signal.
interface pll_clken_if
   import pll_clken_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int DIV_W  = 16
);

   logic                    pll_locked_i;
   logic [NUM_CH*DIV_W-1:0] div_i;
   logic                    realign_i;
   logic [NUM_CH-1:0]       clken_o;
   logic [NUM_CH-1:0]       rst_n_o;
   logic                    ready_o;
   logic [1:0]              state_o;
`ifdef PLL_CLKEN_LOSS_CNT_EN
   logic [LOSS_CNT_W-1:0]   lock_loss_cnt_o;
`endif

   modport master (
      output pll_locked_i, div_i, realign_i,
      input  clken_o, rst_n_o, ready_o, state_o
`ifdef PLL_CLKEN_LOSS_CNT_EN
      , input lock_loss_cnt_o
`endif
   );

   modport slave (
      input  pll_locked_i, div_i, realign_i,
      output clken_o, rst_n_o, ready_o, state_o
`ifdef PLL_CLKEN_LOSS_CNT_EN
      , output lock_loss_cnt_o
`endif
   );

endinterface

// File: rtl/clken_divider.sv
// One clock-enable divider: counts from the RUN-entry (or realign) origin and pulses at
// the last count of each period; the ratio is re-latched only at period boundaries.
module clken_divider
   import pll_clken_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             realign,
   input  logic [DIV_W-1:0] div_i,
   output logic             clken_o
);

   logic             active_q;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             clken_q, clken_d;
   logic             wrap;

   assign wrap = (div_q < DIV_W'(DIV_MIN)) || (cnt_q == div_q - DIV_W'(1));

   // run is the next-cycle RUN flag, so active_q marks cycles already inside RUN
   always_comb begin
      cnt_d   = '0;
      div_d   = '0;
      clken_d = 1'b0;
      if (run) begin
         if (!active_q || realign || wrap) begin
            cnt_d = '0;
            div_d = div_i;
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
            div_d = div_q;
         end
         clken_d = !(active_q && realign) &&
                   ((div_d < DIV_W'(DIV_MIN)) || (cnt_d == div_d - DIV_W'(1)));
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         div_q    <= '0;
         clken_q  <= 1'b0;
      end else begin
         active_q <= run;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         clken_q  <= clken_d;
      end
   end

   assign clken_o = clken_q;

endmodule

// File: rtl/pll_clken_sequencer.sv
// Lock-qualified reset sequencer with NUM_CH phase-aligned clock-enable dividers.
// Define PLL_CLKEN_LOSS_CNT_EN to add the saturating lock-loss counter output.
module pll_clken_sequencer
   import pll_clken_pkg::*;
#(
   parameter int NUM_CH     = 3,
   parameter int DIV_W      = 16,
   parameter int STABLE_CYC = 1024,
   parameter int RST_GAP    = 16
) (
   input  logic        refclk,
   input  logic        rst_n,
   pll_clken_if.slave  bus
);

   localparam int REL_MAX = (NUM_CH - 1) * RST_GAP;
   localparam int REL_W   = (REL_MAX > 0) ? $clog2(REL_MAX + 1) : 1;
   localparam int STAB_W  = $clog2(STABLE_CYC);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   locked_s;
   state_t                 state_q, state_d;
   logic [STAB_W-1:0]      stab_q, stab_d;
   logic [REL_W-1:0]       rel_q, rel_d;
   logic [NUM_CH-1:0]      rst_q, rst_d;
   logic                   ready_q, ready_d;
   logic [NUM_CH-1:0]      clken_w;
   logic                   run_nxt;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked_i};
   end

   assign locked_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT_LOCK;
         stab_q  <= '0;
         rel_q   <= '0;
         rst_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         stab_q  <= stab_d;
         rel_q   <= rel_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
      end
   end

   // Loss of lock takes priority over every forward transition
   always_comb begin
      state_d = state_q;
      stab_d  = stab_q;
      rel_d   = rel_q;
      case (state_q)
         WAIT_LOCK: begin
            stab_d = '0;
            rel_d  = '0;
            if (locked_s) state_d = STABLE;
         end
         STABLE: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               stab_d  = '0;
            end else if (stab_q == STAB_W'(STABLE_CYC - 1)) begin
               state_d = RELEASE;
               stab_d  = '0;
               rel_d   = '0;
            end else begin
               stab_d = stab_q + STAB_W'(1);
            end
         end
         RELEASE: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               rel_d   = '0;
            end else if (rel_q == REL_W'(REL_MAX)) begin
               state_d = RUN;
               rel_d   = '0;
            end else begin
               rel_d = rel_q + REL_W'(1);
            end
         end
         default: begin
            if (!locked_s) state_d = WAIT_LOCK;
         end
      endcase
   end

   // Outputs are derived from the next state so they change on the transition edge
   always_comb begin
      ready_d = (state_d == RUN);
      for (int k = 0; k < NUM_CH; k++) begin
         rst_d[k] = (state_d == RUN) ||
                    ((state_d == RELEASE) && (32'(rel_d) >= 32'(k * RST_GAP)));
      end
   end

   assign run_nxt = (state_d == RUN);

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      clken_divider #(.DIV_W(DIV_W)) u_div (
         .refclk  (refclk),
         .rst_n   (rst_n),
         .run     (run_nxt),
         .realign (bus.realign_i),
         .div_i   (bus.div_i[k*DIV_W +: DIV_W]),
         .clken_o (clken_w[k])
      );
   end

`ifdef PLL_CLKEN_LOSS_CNT_EN
   logic [LOSS_CNT_W-1:0] loss_q, loss_d;

   always_comb begin
      loss_d = loss_q;
      if ((state_q != WAIT_LOCK) && !locked_s && (loss_q != '1))
         loss_d = loss_q + LOSS_CNT_W'(1);
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) loss_q <= '0;
      else        loss_q <= loss_d;
   end

   assign bus.lock_loss_cnt_o = loss_q;
`endif

   assign bus.clken_o = clken_w;
   assign bus.rst_n_o = rst_q;
   assign bus.ready_o = ready_q;
   assign bus.state_o = state_q;

endmodule
